// File: rtl/csr_bridge_pkg.sv
// Shared definitions for the Avalon-MM to CSR register-file bridge:
// FSM state encoding and the supported read-latency range.
package csr_bridge_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/csr_if.sv
// Register-file access interface: the bridge drives address, write data and
// byte enables; the register file returns read data RD_LATENCY cycles later.
interface csr_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 10
);
  logic                   clk;
  logic [A_WIDTH-1:0]     addr;
  logic [D_WIDTH-1:0]     wr_data;
  logic                   wr_en;
  logic [D_WIDTH/8-1:0]   be;
  logic [D_WIDTH-1:0]     rd_data;

  modport master (output clk, addr, wr_data, wr_en, be, input rd_data);
  modport slave  (input clk, addr, wr_data, wr_en, be, output rd_data);
endinterface

// File: rtl/csr_amm_bridge.sv
// Avalon-MM slave to CSR register-file bridge: one outstanding command at a time,
// writes take 2 cycles, reads take RD_LATENCY+2 cycles; waitrequest stalls the master.
module csr_amm_bridge
  import csr_bridge_pkg::*;
#(
  parameter int D_WIDTH    = 16,
  parameter int A_WIDTH    = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [A_WIDTH-1:0]   amm_address_i,
  input  logic                 amm_read_i,
  input  logic                 amm_write_i,
  input  logic [D_WIDTH-1:0]   amm_writedata_i,
  input  logic [D_WIDTH/8-1:0] amm_byteenable_i,
  output logic                 amm_waitrequest_o,
  output logic [D_WIDTH-1:0]   amm_readdata_o,
  output logic                 amm_readdatavalid_o,
  output logic                 proto_err_o,
  csr_if.master                regfile_if
);

  localparam int BE_W = D_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               wr_en_q, wr_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               rvld_q, rvld_d;
  logic               perr_q, perr_d;
  logic               waitreq_q, waitreq_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    be_d      = be_q;
    wr_en_d   = 1'b0;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rvld_d    = 1'b0;
    perr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read is dropped in favour of the write.
        if (amm_write_i) begin
          state_d   = WRITE;
          addr_d    = amm_address_i;
          wr_data_d = amm_writedata_i;
          be_d      = amm_byteenable_i;
          wr_en_d   = 1'b1;
          perr_d    = amm_read_i;
        end else if (amm_read_i) begin
          state_d = RD_WAIT;
          addr_d  = amm_address_i;
          be_d    = amm_byteenable_i;
          cnt_d   = CNT_LOAD;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Capture on the edge the count hits zero so valid is high throughout RD_DONE.
        if (cnt_q == CNT_W'(1)) begin
          state_d = RD_DONE;
          rdata_d = regfile_if.rd_data;
          rvld_d  = 1'b1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    waitreq_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      be_q      <= '0;
      wr_en_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      perr_q    <= 1'b0;
      waitreq_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      be_q      <= be_d;
      wr_en_q   <= wr_en_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
      perr_q    <= perr_d;
      waitreq_q <= waitreq_d;
    end
  end

  assign regfile_if.clk     = clk_i;
  assign regfile_if.addr    = addr_q;
  assign regfile_if.wr_data = wr_data_q;
  assign regfile_if.be      = be_q;
  assign regfile_if.wr_en   = wr_en_q;

  assign amm_waitrequest_o   = waitreq_q;
  assign amm_readdata_o      = rdata_q;
  assign amm_readdatavalid_o = rvld_q;
  assign proto_err_o         = perr_q;

endmodule

// File: tb/tb_csr_amm_bridge.sv
// Directed bench for csr_amm_bridge: dut_a runs with RD_LATENCY=1, dut_b with
// RD_LATENCY=3, each backed by a small byte-enabled register-file model.
module tb_csr_amm_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  logic [9:0]  a_addr, b_addr;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [15:0] a_wdat, b_wdat;
  logic [1:0]  a_be, b_be;
  logic        a_wreq, b_wreq, a_rvld, b_rvld, a_perr, b_perr;
  logic [15:0] a_rdat, b_rdat;

  csr_if #(.D_WIDTH(16), .A_WIDTH(10)) ifa ();
  csr_if #(.D_WIDTH(16), .A_WIDTH(10)) ifb ();

  csr_amm_bridge #(.D_WIDTH(16), .A_WIDTH(10), .RD_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .amm_address_i(a_addr), .amm_read_i(a_rd),
    .amm_write_i(a_wr), .amm_writedata_i(a_wdat), .amm_byteenable_i(a_be),
    .amm_waitrequest_o(a_wreq), .amm_readdata_o(a_rdat),
    .amm_readdatavalid_o(a_rvld), .proto_err_o(a_perr), .regfile_if(ifa)
  );

  csr_amm_bridge #(.D_WIDTH(16), .A_WIDTH(10), .RD_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .amm_address_i(b_addr), .amm_read_i(b_rd),
    .amm_write_i(b_wr), .amm_writedata_i(b_wdat), .amm_byteenable_i(b_be),
    .amm_waitrequest_o(b_wreq), .amm_readdata_o(b_rdat),
    .amm_readdatavalid_o(b_rvld), .proto_err_o(b_perr), .regfile_if(ifb)
  );

  // Register-file models: A reads combinationally, B through two pipeline stages.
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [64];
  logic [15:0] pb0, pb1;

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_v;
    if (be[0]) r[7:0]  = new_v[7:0];
    if (be[1]) r[15:8] = new_v[15:8];
    return r;
  endfunction

  assign ifa.rd_data = mem_a[ifa.addr[5:0]];
  assign ifb.rd_data = pb1;

  always @(posedge clk) begin
    if (ifa.wr_en) mem_a[ifa.addr[5:0]] <= merge(mem_a[ifa.addr[5:0]], ifa.wr_data, ifa.be);
  end

  always @(posedge clk) begin
    pb0 <= mem_b[ifb.addr[5:0]];
    pb1 <= pb0;
    if (ifb.wr_en) mem_b[ifb.addr[5:0]] <= merge(mem_b[ifb.addr[5:0]], ifb.wr_data, ifb.be);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_wreq !== 1'b1) begin bad++; $display("FAIL rst_wreq: got %b want 1", a_wreq); end
    total++; if ({a_rvld, a_perr, ifa.wr_en} !== 3'b000) begin bad++; $display("FAIL rst_strobes: got %b want 000", {a_rvld, a_perr, ifa.wr_en}); end
    total++; if ({ifa.addr, ifa.wr_data, ifa.be, a_rdat} !== 44'h0) begin bad++; $display("FAIL rst_regs: got %h want 0", {ifa.addr, ifa.wr_data, ifa.be, a_rdat}); end
    total++; if (b_wreq !== 1'b1) begin bad++; $display("FAIL rst_wreq_b: got %b want 1", b_wreq); end
    rst = 1'b0;
    #1;
    total++; if (a_wreq !== 1'b1) begin bad++; $display("FAIL rst_wreq_hold: got %b want 1", a_wreq); end
    tick();
    total++; if ({a_wreq, b_wreq} !== 2'b00) begin bad++; $display("FAIL rst_release: got %b want 00", {a_wreq, b_wreq}); end
  endtask

  task automatic test_write();
    a_wr = 1'b1; a_addr = 10'h005; a_wdat = 16'hBEEF; a_be = 2'b11;
    total++; if (a_wreq !== 1'b0) begin bad++; $display("FAIL wr_idle_wreq: got %b want 0", a_wreq); end
    tick();
    a_wr = 1'b0;
    total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("FAIL wr_en: got %b want 1", ifa.wr_en); end
    total++; if (ifa.addr !== 10'h005) begin bad++; $display("FAIL wr_addr: got %h want 005", ifa.addr); end
    total++; if (ifa.wr_data !== 16'hBEEF) begin bad++; $display("FAIL wr_data: got %h want beef", ifa.wr_data); end
    total++; if ({a_wreq, ifa.be, a_perr} !== 4'b1110) begin bad++; $display("FAIL wr_wreq_be: got %b want 1110", {a_wreq, ifa.be, a_perr}); end
    tick();
    total++; if ({ifa.wr_en, a_wreq} !== 2'b00) begin bad++; $display("FAIL wr_done: got %b want 00", {ifa.wr_en, a_wreq}); end
  endtask

  task automatic test_read_lat1();
    a_rd = 1'b1; a_addr = 10'h005;
    tick();
    a_rd = 1'b0;
    total++; if ({a_rvld, a_wreq, ifa.wr_en} !== 3'b010) begin bad++; $display("FAIL rd1_n1: got %b want 010", {a_rvld, a_wreq, ifa.wr_en}); end
    total++; if (ifa.addr !== 10'h005) begin bad++; $display("FAIL rd1_addr: got %h want 005", ifa.addr); end
    tick();
    total++; if ({a_rvld, ifa.wr_en} !== 2'b10) begin bad++; $display("FAIL rd1_vld: got %b want 10", {a_rvld, ifa.wr_en}); end
    total++; if (a_rdat !== 16'hBEEF) begin bad++; $display("FAIL rd1_data: got %h want beef", a_rdat); end
    tick();
    total++; if ({a_rvld, a_wreq} !== 2'b00) begin bad++; $display("FAIL rd1_end: got %b want 00", {a_rvld, a_wreq}); end
    total++; if (a_rdat !== 16'hBEEF) begin bad++; $display("FAIL rd1_hold: got %h want beef", a_rdat); end
  endtask

  task automatic test_byteenable();
    a_wr = 1'b1; a_addr = 10'h005; a_wdat = 16'h1234; a_be = 2'b01;
    tick();
    a_wr = 1'b0;
    total++; if ({ifa.wr_en, ifa.be} !== 3'b101) begin bad++; $display("FAIL be_pass: got %b want 101", {ifa.wr_en, ifa.be}); end
    tick();
    a_rd = 1'b1; a_be = 2'b11;
    tick();
    a_rd = 1'b0;
    tick();
    total++; if ({a_rvld, a_rdat} !== {1'b1, 16'hBE34}) begin bad++; $display("FAIL be_readback: got %b/%h want 1/be34", a_rvld, a_rdat); end
    tick();
  endtask

  task automatic test_proto_err();
    int n_evt;
    n_evt = 0;
    a_rd = 1'b1; a_wr = 1'b1; a_addr = 10'h010; a_wdat = 16'hA5A5; a_be = 2'b11;
    tick();
    a_rd = 1'b0; a_wr = 1'b0;
    total++; if ({a_perr, ifa.wr_en, a_rvld} !== 3'b110) begin bad++; $display("FAIL perr_pulse: got %b want 110", {a_perr, ifa.wr_en, a_rvld}); end
    total++; if (ifa.addr !== 10'h010) begin bad++; $display("FAIL perr_addr: got %h want 010", ifa.addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_perr || a_rvld || ifa.wr_en) n_evt++;
    end
    total++; if (n_evt !== 0) begin bad++; $display("FAIL perr_after: got %0d strobes want 0", n_evt); end
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    tick();
    total++; if ({a_rvld, a_rdat} !== {1'b1, 16'hA5A5}) begin bad++; $display("FAIL perr_readback: got %b/%h want 1/a5a5", a_rvld, a_rdat); end
    tick();
  endtask

  task automatic b_write(input logic [9:0] addr, input logic [15:0] data);
    b_wr = 1'b1; b_addr = addr; b_wdat = data; b_be = 2'b11;
    tick();
    b_wr = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_vld, exp_wreq;
    logic [15:0] exp_dat;
    b_write(10'h001, 16'h1111);
    b_write(10'h002, 16'h2222);
    b_rd = 1'b1; b_addr = 10'h001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) b_addr = 10'h002;
      if (c == 6) b_rd = 1'b0;
      exp_vld  = (c == 4) || (c == 9);
      exp_wreq = (c != 5) && (c != 10);
      exp_dat  = (c == 9) ? 16'h2222 : 16'h1111;
      total++; if ({b_rvld, b_wreq, ifb.wr_en} !== {exp_vld, exp_wreq, 1'b0}) begin bad++; $display("FAIL b2b_c%0d: vld/wreq/wen got %b want %b", c, {b_rvld, b_wreq, ifb.wr_en}, {exp_vld, exp_wreq, 1'b0}); end
      if (exp_vld) begin
        total++; if (b_rdat !== exp_dat) begin bad++; $display("FAIL b2b_data_c%0d: got %h want %h", c, b_rdat, exp_dat); end
      end
      if (c == 3) begin
        total++; if (ifb.addr !== 10'h001) begin bad++; $display("FAIL b2b_addr_hold: got %h want 001", ifb.addr); end
      end
      if (c == 7) begin
        total++; if (ifb.addr !== 10'h002) begin bad++; $display("FAIL b2b_addr2: got %h want 002", ifb.addr); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int n_vld;
    n_vld = 0;
    b_rd = 1'b1; b_addr = 10'h002;
    tick();
    b_rd = 1'b0;
    total++; if (b_wreq !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", b_wreq); end
    rst = 1'b1;
    #1;
    total++; if ({b_wreq, b_rvld, b_perr, ifb.wr_en} !== 4'b1000) begin bad++; $display("FAIL mid_strobes: got %b want 1000", {b_wreq, b_rvld, b_perr, ifb.wr_en}); end
    total++; if ({ifb.addr, ifb.be, ifb.wr_data, b_rdat} !== 44'h0) begin bad++; $display("FAIL mid_regs: got %h want 0", {ifb.addr, ifb.be, ifb.wr_data, b_rdat}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (b_rvld) n_vld++;
    end
    rst = 1'b0;
    tick();
    total++; if (b_wreq !== 1'b0) begin bad++; $display("FAIL mid_release: got %b want 0", b_wreq); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_rvld || ifb.wr_en) n_vld++;
    end
    total++; if (n_vld !== 0) begin bad++; $display("FAIL mid_abort: got %0d strobes want 0", n_vld); end
  endtask

  initial begin
    a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wdat = '0; a_be = '0;
    b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wdat = '0; b_be = '0;
    test_reset();
    test_write();
    test_read_lat1();
    test_byteenable();
    test_proto_err();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
